// File: rtl/sd_spi_mmio_if.sv
// CPU-side register bus for the SD SPI peripheral.
// The SoC decoder supplies sel; the peripheral decodes only the word offset.
interface sd_spi_mmio_if;
    logic        sel;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [31:0] rdata;

    modport master (output sel, addr, wdata, we, re, input rdata);
    modport slave  (input sel, addr, wdata, we, re, output rdata);
endinterface

// File: rtl/sd_spi_mmio.sv
// Memory-mapped SPI mode-0 master for an SD card.
// Provides TX/RX byte FIFOs, a programmable SCK divider and manual chip select.
module sd_spi_mmio #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] DIV_RESET  = 8'd30
) (
    input  logic          clk25,
    input  logic          rst,
    sd_spi_mmio_if.slave  bus,
    output logic          sd_clk,
    output logic          sd_mosi,
    input  logic          sd_miso,
    output logic          sd_cs_n
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH} state_t;

    logic w_wr_data, w_wr_stat, w_wr_ctrl, w_rd_data;
    assign w_wr_data = bus.sel & bus.we & (bus.addr == 2'd0);
    assign w_wr_stat = bus.sel & bus.we & (bus.addr == 2'd1);
    assign w_wr_ctrl = bus.sel & bus.we & (bus.addr == 2'd2);
    assign w_rd_data = bus.sel & bus.re & (bus.addr == 2'd0);

    // FIFO index 0 is TX (bus -> shifter), index 1 is RX (shifter -> bus)
    logic [1:0] w_push, w_pop, w_full, w_empty;
    logic [7:0] w_din  [2];
    logic [7:0] w_head [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            logic [7:0]    r_mem [FIFO_DEPTH];
            logic [PW-1:0] r_wp, r_rp;
            logic [CW-1:0] r_cnt;

            always_ff @(posedge clk25) begin
                if (w_push[gi]) r_mem[r_wp] <= w_din[gi];
            end

            always_ff @(posedge clk25) begin
                if (rst) begin
                    r_wp  <= '0;
                    r_rp  <= '0;
                    r_cnt <= '0;
                end else begin
                    if (w_push[gi]) r_wp <= r_wp + PW'(1);
                    if (w_pop[gi])  r_rp <= r_rp + PW'(1);
                    if (w_push[gi] && !w_pop[gi])      r_cnt <= r_cnt + CW'(1);
                    else if (w_pop[gi] && !w_push[gi]) r_cnt <= r_cnt - CW'(1);
                end
            end

            assign w_head[gi]  = r_mem[r_rp];
            assign w_full[gi]  = (r_cnt == CW'(FIFO_DEPTH));
            assign w_empty[gi] = (r_cnt == '0);
        end
    endgenerate

    state_t     r_state, w_state_next;
    logic [7:0] r_div_cnt, w_div_cnt_next;
    logic [7:0] r_div_l, w_div_l_next;
    logic [2:0] r_bit_cnt, w_bit_cnt_next;
    logic [7:0] r_shift, w_shift_next;
    logic       r_miso, w_miso_next;
    logic       r_mosi, w_mosi_next;
    logic       r_sck, w_sck_next;
    logic       w_tx_take, w_rx_push, w_miso_bit;
    logic [7:0] w_rx_byte;
    logic [7:0] r_div;
    logic       r_cs_en, r_tx_ovf, r_rx_ovf;
    logic [31:0] r_rdata;

    // On a 1-cycle HIGH phase the sample and the exit coincide, so use the pin directly
    assign w_miso_bit = (r_div_cnt == 8'd0) ? sd_miso : r_miso;
    assign w_rx_byte  = {r_shift[6:0], w_miso_bit};

    always_comb begin
        w_state_next   = r_state;
        w_div_cnt_next = r_div_cnt;
        w_div_l_next   = r_div_l;
        w_bit_cnt_next = r_bit_cnt;
        w_shift_next   = r_shift;
        w_miso_next    = r_miso;
        w_mosi_next    = r_mosi;
        w_sck_next     = 1'b0;
        w_tx_take      = 1'b0;
        w_rx_push      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_mosi_next = 1'b1;
                if (!w_empty[0]) begin
                    w_tx_take      = 1'b1;
                    w_shift_next   = w_head[0];
                    w_div_l_next   = r_div;
                    w_mosi_next    = w_head[0][7];
                    w_bit_cnt_next = 3'd0;
                    w_div_cnt_next = 8'd0;
                    w_state_next   = S_LOW;
                end
            end
            S_LOW: begin
                if (r_div_cnt == r_div_l) begin
                    w_div_cnt_next = 8'd0;
                    w_sck_next     = 1'b1;
                    w_state_next   = S_HIGH;
                end else begin
                    w_div_cnt_next = r_div_cnt + 8'd1;
                end
            end
            S_HIGH: begin
                w_sck_next = 1'b1;
                if (r_div_cnt == 8'd0) w_miso_next = sd_miso;
                if (r_div_cnt == r_div_l) begin
                    w_div_cnt_next = 8'd0;
                    w_sck_next     = 1'b0;
                    if (r_bit_cnt == 3'd7) begin
                        w_rx_push    = 1'b1;
                        w_mosi_next  = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_shift_next   = w_rx_byte;
                        w_mosi_next    = r_shift[6];
                        w_bit_cnt_next = r_bit_cnt + 3'd1;
                        w_state_next   = S_LOW;
                    end
                end else begin
                    w_div_cnt_next = r_div_cnt + 8'd1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk25) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_div_cnt <= 8'd0;
            r_div_l   <= 8'd0;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'd0;
            r_miso    <= 1'b0;
            r_mosi    <= 1'b1;
            r_sck     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_div_cnt <= w_div_cnt_next;
            r_div_l   <= w_div_l_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_shift   <= w_shift_next;
            r_miso    <= w_miso_next;
            r_mosi    <= w_mosi_next;
            r_sck     <= w_sck_next;
        end
    end

    // A push into a full FIFO is accepted when the same cycle also pops it
    assign w_din[0]  = bus.wdata[7:0];
    assign w_din[1]  = w_rx_byte;
    assign w_pop[0]  = w_tx_take;
    assign w_pop[1]  = w_rd_data & ~w_empty[1];
    assign w_push[0] = w_wr_data & (~w_full[0] | w_pop[0]);
    assign w_push[1] = w_rx_push & (~w_full[1] | w_pop[1]);

    always_ff @(posedge clk25) begin
        if (rst) begin
            r_div    <= DIV_RESET;
            r_cs_en  <= 1'b0;
            r_tx_ovf <= 1'b0;
            r_rx_ovf <= 1'b0;
            r_rdata  <= 32'd0;
        end else begin
            if (w_wr_ctrl) begin
                r_cs_en <= bus.wdata[0];
                r_div   <= bus.wdata[15:8];
            end
            if (w_wr_data && w_full[0] && !w_pop[0]) r_tx_ovf <= 1'b1;
            else if (w_wr_stat && bus.wdata[3])      r_tx_ovf <= 1'b0;
            if (w_rx_push && w_full[1] && !w_pop[1]) r_rx_ovf <= 1'b1;
            else if (w_wr_stat && bus.wdata[4])      r_rx_ovf <= 1'b0;
            if (bus.sel && bus.re) begin
                case (bus.addr)
                    2'd0:    r_rdata <= w_empty[1] ? 32'd0 : {24'd0, w_head[1]};
                    2'd1:    r_rdata <= {27'd0, r_rx_ovf, r_tx_ovf, w_empty[1], w_full[0],
                                         (r_state != S_IDLE) | ~w_empty[0]};
                    2'd2:    r_rdata <= {16'd0, r_div, 7'd0, r_cs_en};
                    default: r_rdata <= 32'd0;
                endcase
            end
        end
    end

    logic w_unused;
    assign w_unused = ^{bus.wdata[31:16], r_shift[7]};

    assign bus.rdata = r_rdata;
    assign sd_clk    = r_sck;
    assign sd_mosi   = r_mosi;
    assign sd_cs_n   = ~r_cs_en;
endmodule

// File: tb/tb_sd_spi_mmio.sv
// Directed bench for sd_spi_mmio: register access, SCK timing, FIFO overflow and reset abort.
// A negedge monitor records every SCK pulse (MOSI bit, phase lengths, edge times).
module tb_sd_spi_mmio;
    logic clk25 = 1'b0;
    always #20 clk25 = ~clk25;

    logic rst = 1'b1;
    logic sd_clk, sd_mosi, sd_miso, sd_cs_n;
    logic loop_en = 1'b1;
    logic miso_drv = 1'b0;
    assign sd_miso = loop_en ? sd_mosi : miso_drv;

    sd_spi_mmio_if bus();

    sd_spi_mmio #(.FIFO_DEPTH(4), .DIV_RESET(8'd30)) dut (
        .clk25   (clk25),
        .rst     (rst),
        .bus     (bus),
        .sd_clk  (sd_clk),
        .sd_mosi (sd_mosi),
        .sd_miso (sd_miso),
        .sd_cs_n (sd_cs_n)
    );

    int checks = 0;
    int errors = 0;

    int   n_pulses = 0;
    int   run = 0;
    int   cyc = 0;
    logic prev_sck = 1'b0;
    int   hi_len   [256];
    int   lo_len   [256];
    int   rise_cyc [256];
    int   fall_cyc [256];
    logic mosi_bit [256];

    always @(negedge clk25) begin
        cyc      <= cyc + 1;
        prev_sck <= sd_clk;
        if (sd_clk != prev_sck) begin
            run <= 1;
            if (sd_clk) begin
                lo_len[n_pulses & 255]   <= run;
                mosi_bit[n_pulses & 255] <= sd_mosi;
                rise_cyc[n_pulses & 255] <= cyc;
            end else begin
                hi_len[n_pulses & 255]   <= run;
                fall_cyc[n_pulses & 255] <= cyc;
                n_pulses <= n_pulses + 1;
            end
        end else begin
            run <= run + 1;
        end
    end

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus.sel = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d;
        @(posedge clk25); #1;
        bus.sel = 1'b0; bus.we = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        bus.sel = 1'b1; bus.re = 1'b1; bus.addr = a;
        @(posedge clk25); #1;
        bus.sel = 1'b0; bus.re = 1'b0;
        d = bus.rdata;
    endtask

    task automatic wait_pulses(input int target, input int budget, input string name);
        int k = 0;
        while (n_pulses < target && k < budget) begin
            @(posedge clk25); #1;
            k++;
        end
        checks++;
        if (n_pulses < target) begin
            errors++;
            $display("FAIL %s pulse_timeout got %0d want %0d", name, n_pulses, target);
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        logic [31:0] d;
        int k = 0;
        bus_read(2'd1, d);
        while (d[0] && k < budget) begin
            bus_read(2'd1, d);
            k++;
        end
        checks++;
        if (d[0]) begin
            errors++;
            $display("FAIL %s idle_timeout status %h", name, d);
        end
    endtask

    // Returns the byte seen on MOSI for 8 pulses starting at index p0
    function automatic logic [7:0] wire_byte(input int p0);
        logic [7:0] b = 8'd0;
        for (int i = 0; i < 8; i++) b = {b[6:0], mosi_bit[(p0 + i) & 255]};
        return b;
    endfunction

    task automatic test_reset();
        logic [31:0] d;
        bus.sel = 1'b0; bus.we = 1'b0; bus.re = 1'b0; bus.addr = 2'd0; bus.wdata = 32'd0;
        rst = 1'b1;
        repeat (2) @(posedge clk25);
        #1 rst = 1'b0;
        checks++;
        if ({sd_cs_n, sd_clk, sd_mosi} !== 3'b101) begin
            errors++; $display("FAIL reset_pins got %b want 101", {sd_cs_n, sd_clk, sd_mosi});
        end
        checks++;
        if (bus.rdata !== 32'd0) begin
            errors++; $display("FAIL reset_rdata got %h want 00000000", bus.rdata);
        end
        bus_read(2'd1, d);
        checks++;
        if (d !== 32'h4) begin errors++; $display("FAIL reset_status got %h want 00000004", d); end
        bus_read(2'd2, d);
        checks++;
        if (d !== 32'h1E00) begin errors++; $display("FAIL reset_ctrl got %h want 00001e00", d); end
        bus_read(2'd3, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_reserved got %h want 00000000", d); end
    endtask

    task automatic test_loopback();
        logic [31:0] d;
        int n0, hi_bad, lo_bad;
        loop_en = 1'b1;
        bus_write(2'd2, 32'h0000_0001);
        checks++;
        if (sd_cs_n !== 1'b0) begin errors++; $display("FAIL loop_cs_n got %b want 0", sd_cs_n); end
        n0 = n_pulses;
        bus.sel = 1'b1; bus.we = 1'b1; bus.addr = 2'd0; bus.wdata = 32'hA5;
        @(posedge clk25); #1;
        bus.sel = 1'b0; bus.we = 1'b0;
        repeat (16) @(posedge clk25);
        #1 bus.sel = 1'b1; bus.re = 1'b1; bus.addr = 2'd1;
        @(posedge clk25); #1;
        d = bus.rdata;
        checks++;
        if (d !== 32'h5) begin errors++; $display("FAIL loop_busy_at16 got %h want 00000005", d); end
        @(posedge clk25); #1;
        bus.sel = 1'b0; bus.re = 1'b0;
        d = bus.rdata;
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL loop_busy_at17 got %h want 00000000", d); end
        wait_pulses(n0 + 8, 50, "loop");
        hi_bad = 0; lo_bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (hi_len[(n0 + i) & 255] != 1) hi_bad++;
            if (i > 0 && lo_len[(n0 + i) & 255] != 1) lo_bad++;
        end
        checks++;
        if (wire_byte(n0) !== 8'hA5) begin
            errors++; $display("FAIL loop_mosi got %h want a5", wire_byte(n0));
        end
        checks++;
        if (hi_bad != 0 || lo_bad != 0) begin
            errors++; $display("FAIL loop_phases got hi_bad %0d lo_bad %0d want 0 0", hi_bad, lo_bad);
        end
        checks++;
        if (fall_cyc[(n0 + 7) & 255] - rise_cyc[n0 & 255] != 15) begin
            errors++; $display("FAIL loop_span got %0d want 15",
                               fall_cyc[(n0 + 7) & 255] - rise_cyc[n0 & 255]);
        end
        bus_read(2'd0, d);
        checks++;
        if (d !== 32'hA5) begin errors++; $display("FAIL loop_data got %h want 000000a5", d); end
        bus_read(2'd1, d);
        checks++;
        if (d !== 32'h4) begin errors++; $display("FAIL loop_status got %h want 00000004", d); end
    endtask

    task automatic test_slow_div();
        logic [31:0] d;
        int n0, bad;
        loop_en = 1'b0; miso_drv = 1'b0;
        bus_write(2'd2, 32'h0000_1E01);
        n0 = n_pulses;
        bus_write(2'd0, 32'hFF);
        wait_pulses(n0 + 8, 1000, "slow");
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (hi_len[(n0 + i) & 255] != 31) bad++;
            if (i > 0 && lo_len[(n0 + i) & 255] != 31) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL slow_phases got %0d bad phases want 0", bad); end
        checks++;
        if (fall_cyc[(n0 + 7) & 255] - rise_cyc[n0 & 255] != 465) begin
            errors++; $display("FAIL slow_span got %0d want 465",
                               fall_cyc[(n0 + 7) & 255] - rise_cyc[n0 & 255]);
        end
        checks++;
        if (wire_byte(n0) !== 8'hFF) begin
            errors++; $display("FAIL slow_mosi got %h want ff", wire_byte(n0));
        end
        wait_idle(20, "slow");
        bus_read(2'd1, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL slow_status got %h want 00000000", d); end
        bus_read(2'd0, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL slow_data got %h want 00000000", d); end
        bus_read(2'd1, d);
        checks++;
        if (d !== 32'h4) begin errors++; $display("FAIL slow_status_after got %h want 00000004", d); end
    endtask

    task automatic test_tx_overflow();
        logic [31:0] d;
        logic [7:0] tx [6];
        int n0, bad;
        tx = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        loop_en = 1'b1;
        n0 = n_pulses;
        for (int i = 0; i < 6; i++) bus_write(2'd0, {24'd0, tx[i]});
        bus_read(2'd1, d);
        checks++;
        if (d !== 32'h0F) begin errors++; $display("FAIL txovf_status got %h want 0000000f", d); end
        bus_write(2'd1, 32'h08);
        bus_read(2'd1, d);
        checks++;
        if (d !== 32'h07) begin errors++; $display("FAIL txovf_clear got %h want 00000007", d); end
        wait_pulses(n0 + 40, 2800, "txovf");
        repeat (100) @(posedge clk25);
        #1;
        checks++;
        if (n_pulses != n0 + 40) begin
            errors++; $display("FAIL txovf_pulses got %0d want %0d", n_pulses - n0, 40);
        end
        bad = 0;
        for (int b = 0; b < 5; b++) if (wire_byte(n0 + 8 * b) !== tx[b]) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL txovf_wire got %0d bad bytes want 0", bad); end
        wait_idle(20, "txovf");
        bus_read(2'd1, d);
        checks++;
        if (d !== 32'h10) begin errors++; $display("FAIL rxovf_status got %h want 00000010", d); end
        for (int i = 0; i < 4; i++) begin
            bus_read(2'd0, d);
            checks++;
            if (d !== {24'd0, tx[i]}) begin
                errors++; $display("FAIL rxovf_data%0d got %h want %h", i, d, tx[i]);
            end
        end
        bus_read(2'd0, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL rxovf_empty got %h want 00000000", d); end
        bus_read(2'd1, d);
        checks++;
        if (d !== 32'h14) begin errors++; $display("FAIL rxovf_status2 got %h want 00000014", d); end
        bus_write(2'd1, 32'h10);
        bus_read(2'd1, d);
        checks++;
        if (d !== 32'h04) begin errors++; $display("FAIL rxovf_clear got %h want 00000004", d); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [7:0] tx [5];
        int n0;
        tx = '{8'h3C, 8'hC3, 8'h5A, 8'h81, 8'h7E};
        loop_en = 1'b1;
        bus_write(2'd2, 32'h0000_0001);
        n0 = n_pulses;
        for (int i = 0; i < 4; i++) bus_write(2'd0, {24'd0, tx[i]});
        wait_idle(200, "b2b");
        checks++;
        if (lo_len[(n0 + 8) & 255] != 2) begin
            errors++; $display("FAIL b2b_gap got %0d want 2", lo_len[(n0 + 8) & 255]);
        end
        // Fifth byte: its RX push coincides with a DATA read of the full RX FIFO
        bus.sel = 1'b1; bus.we = 1'b1; bus.addr = 2'd0; bus.wdata = {24'd0, tx[4]};
        @(posedge clk25); #1;
        bus.sel = 1'b0; bus.we = 1'b0;
        repeat (16) @(posedge clk25);
        #1 bus.sel = 1'b1; bus.re = 1'b1; bus.addr = 2'd0;
        @(posedge clk25); #1;
        bus.sel = 1'b0; bus.re = 1'b0;
        d = bus.rdata;
        checks++;
        if (d !== 32'h3C) begin errors++; $display("FAIL b2b_pop_push got %h want 0000003c", d); end
        wait_idle(20, "b2b");
        bus_read(2'd1, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL b2b_status got %h want 00000000", d); end
        for (int i = 1; i < 5; i++) begin
            bus_read(2'd0, d);
            checks++;
            if (d !== {24'd0, tx[i]}) begin
                errors++; $display("FAIL b2b_data%0d got %h want %h", i, d, tx[i]);
            end
        end
        bus_read(2'd0, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL b2b_empty got %h want 00000000", d); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        int n0;
        bus_write(2'd2, 32'h0000_0201);
        n0 = n_pulses;
        bus_write(2'd0, 32'hAB);
        wait_pulses(n0 + 3, 200, "rstmid");
        rst = 1'b1;
        repeat (2) @(posedge clk25);
        #1 rst = 1'b0;
        checks++;
        if ({sd_cs_n, sd_clk, sd_mosi} !== 3'b101) begin
            errors++; $display("FAIL rstmid_pins got %b want 101", {sd_cs_n, sd_clk, sd_mosi});
        end
        bus_read(2'd2, d);
        checks++;
        if (d !== 32'h1E00) begin errors++; $display("FAIL rstmid_ctrl got %h want 00001e00", d); end
        repeat (60) @(posedge clk25);
        #1;
        bus_read(2'd1, d);
        checks++;
        if (d !== 32'h4) begin errors++; $display("FAIL rstmid_status got %h want 00000004", d); end
        bus_read(2'd0, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL rstmid_data got %h want 00000000", d); end
        checks++;
        if (n_pulses != n0 + 3) begin
            errors++; $display("FAIL rstmid_pulses got %0d want 3", n_pulses - n0);
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_slow_div();
        test_tx_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sd_spi_mmio.md
Name: sd_spi_mmio

Overview:
- Memory-mapped SPI master peripheral placed directly between the CPU data bus and the SD card pins.
- Gives firmware a TX FIFO, an RX FIFO, a programmable SCK divider and manual chip-select control.
- Firmware drives SD init at roughly 400 kHz and data transfer at full speed over SPI mode 0.
- Decodes the word offset only; the SoC address decoder supplies `sel`.

Parameters:
- FIFO_DEPTH, 4, entries in each of the TX and RX FIFOs (power of 2, at least 2).
- DIV_RESET, 30, reset value of the divider; each SCK half-period lasts DIV+1 clk25 cycles (30 gives about 403 kHz).

Ports:
- clk25, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- sel, input, 1, peripheral selected by the SoC address decoder.
- addr, input, 2, word offset: 0 = DATA, 1 = STATUS, 2 = CTRL, 3 = reserved.
- wdata, input, 32, bus write data.
- we, input, 1, write strobe, single cycle, qualified by sel.
- re, input, 1, read strobe, single cycle, qualified by sel.
- rdata, output, 32, registered read data.
- sd_clk, output, 1, SPI SCK.
- sd_mosi, output, 1, SPI MOSI.
- sd_miso, input, 1, SPI MISO.
- sd_cs_n, output, 1, card chip select, active low.

Behaviour:
- Reset values:
  - rdata = 0, sd_clk = 0, sd_mosi = 1, sd_cs_n = 1.
  - Both FIFOs empty, DIV = DIV_RESET, cs_en = 0, sticky flags = 0, FSM in IDLE.
- Reset mid-byte aborts the transfer immediately; no partial byte is pushed to RX.
- Bus reads:
  - rdata is valid on the cycle after sel&re; rdata holds its value when no read occurs.
  - DATA read: returns {24'b0, RX head} and pops RX. If RX is empty, returns 0 and does not pop.
  - STATUS read: [0] busy (FSM not IDLE or TX not empty), [1] tx_full, [2] rx_empty, [3] tx_ovf, [4] rx_ovf.
  - CTRL read: [0] cs_en, [15:8] DIV.
  - Reserved offset and all unused bits read as 0.
- Bus writes:
  - DATA: pushes wdata[7:0] into TX. If TX is full, the byte is dropped and tx_ovf is set.
  - STATUS: writing 1 to bit 3 clears tx_ovf; writing 1 to bit 4 clears rx_ovf. A set event in the same cycle wins over the clear.
  - CTRL: cs_en = wdata[0] and DIV = wdata[15:8].
  - sd_cs_n = ~cs_en, updated the cycle after the write, even if a transfer is in progress (sequencing CS is firmware's job).
- FSM states: IDLE, LOW, HIGH.
  - IDLE:
    - sd_clk = 0.
    - If TX is not empty: pop TX into the 8-bit shift register, latch DIV into div_l, drive sd_mosi = bit7, bit count = 0, go to LOW.
    - A DIV change therefore takes effect only at the next byte.
  - LOW:
    - sd_clk = 0 for div_l+1 cycles, then go to HIGH.
  - HIGH:
    - sd_clk = 1 for div_l+1 cycles.
    - sd_miso is sampled into the shift register LSB on the first HIGH cycle (SCK rising edge).
    - On exit, if bit count < 7: shift, drive the next bit on sd_mosi, increment the count, go to LOW.
    - After the 8th bit: push the received byte to RX and go to IDLE.
    - If RX is full at that push, the byte is dropped and rx_ovf is set.
  - MSB first, SPI mode 0.
- sd_mosi returns to 1 in IDLE.
- Byte time = 16*(div_l+1) cycles, plus 1 IDLE cycle between back-to-back bytes.
- FIFOs use pointer wrap modulo FIFO_DEPTH plus a count of width log2(FIFO_DEPTH)+1.
- Simultaneous push and pop on the same FIFO, including when it is full, executes both and the count is unchanged; this is not an overflow.
- A TX write in the same cycle that IDLE pops a full TX FIFO is accepted.
- Simultaneous we and re: both are executed.

Test Plan:
- Reset: assert rst for 2 cycles → sd_cs_n=1, sd_clk=0, sd_mosi=1; STATUS reads 0x04; CTRL reads 0x1E00.
- Loopback timing: set CTRL=0x0001 (DIV=0, CS low), tie MISO to MOSI, write DATA=0xA5 → 8 SCK pulses, each 1 cycle high and 1 cycle low; MOSI bits 1,0,1,0,0,1,0,1; busy clears after 17 cycles; DATA read returns 0xA5 and STATUS then reads 0x04.
- Slow divider: set DIV=30, write 0xFF with MISO held at 0 → SCK high and low phases each 31 cycles; byte completes in 496 cycles; DATA read returns 0x00.
- TX overflow: with DIV=30, write 6 bytes back-to-back → first byte enters the shifter and the next 4 fill TX, so the 6th is dropped. Expect tx_ovf=1, exactly 5 bytes on the wire, and tx_ovf cleared by writing STATUS=0x08.
- RX overflow and simultaneous access:
  - Send 5 bytes without reading → rx_ovf=1 and RX holds the first 4 bytes.
  - Pop RX on the same cycle a new byte is pushed → count is unchanged and rx_ovf is not set.
- Reset mid-byte: assert rst after 3 SCK pulses → all outputs return to reset values, RX is empty, and no byte is pushed.
